// File: rtl/pc_seq_unit_pkg.sv
// Shared definitions for the PC sequencer: next-PC select encoding and
// default parameter values.
package pc_pkg;

  localparam int PC_WIDTH_DEF = 16;
  localparam int PC_INC_DEF   = 2;
  localparam int RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_RET  = 2'd1,
    SEL_JB   = 2'd2,
    SEL_INC  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_seq_unit_if.sv
// Control/address bundle between decode/branch logic, fetch and the PC
// sequencer. The master drives control; the slave (sequencer) drives PC and status.
interface pc_seq_unit_if
  import pc_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
);

  logic                Stall;
  logic                JBP_enable;
  logic [PC_WIDTH-1:0] JB_Target;
  logic                Call;
  logic                Ret;
  logic [PC_WIDTH-1:0] PC_Out;
  logic [PC_WIDTH-1:0] PC_Next;
  logic                RAS_Empty;
  logic                RAS_Full;
  logic                RAS_Err;

  modport master (
    output Stall, JBP_enable, JB_Target, Call, Ret,
    input  PC_Out, PC_Next, RAS_Empty, RAS_Full, RAS_Err
  );

  modport slave (
    input  Stall, JBP_enable, JB_Target, Call, Ret,
    output PC_Out, PC_Next, RAS_Empty, RAS_Full, RAS_Err
  );

endinterface

// File: rtl/pc_seq_unit_ras.sv
// Return-address stack as a circular buffer: a push when full overwrites
// the oldest entry; push-when-full and pop-when-empty set a sticky error.
module pc_ras
  import pc_pkg::*;
#(
  parameter int RAS_DEPTH = 4,
  parameter int PC_WIDTH  = PC_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [PC_WIDTH-1:0] push_data_i,
  output logic [PC_WIDTH-1:0] top_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                err_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    top_ptr;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;

  // wr_ptr_q is the next free slot; the top is the slot just below it.
  assign top_ptr = wr_ptr_q - PTR_W'(1);
  assign top_o   = mem_q[top_ptr];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign err_o   = err_q;

  // NOTE: storage has no reset; validity is tracked by cnt_q, so resetting the
  // array would only add reset fan-out to every flop.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else if (push_i) begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (full_o) begin
        err_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (pop_i) begin
      if (empty_o) begin
        err_q <= 1'b1;
      end else begin
        wr_ptr_q <= top_ptr;
        cnt_q    <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: PC register, next-PC priority mux and RAS.
// Optional alignment check is enabled by defining PC_ALIGN_CHECK_EN.
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int PC_WIDTH  = PC_WIDTH_DEF,
  parameter int PC_INC    = PC_INC_DEF,
  parameter int RESET_PC  = RESET_PC_DEF,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef PC_ALIGN_CHECK_EN
  output logic          Misalign,
`endif
  pc_seq_unit_if.slave  bus
);

  localparam logic [PC_WIDTH-1:0] INC_W   = PC_WIDTH'(PC_INC);
  localparam logic [PC_WIDTH-1:0] RESET_W = PC_WIDTH'(RESET_PC);

  pc_sel_e             sel;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_empty;
  logic                ras_push;
  logic                ras_pop;

  assign pc_inc   = pc_q + INC_W;
  assign ras_pop  = !bus.Stall && bus.Ret;
  assign ras_push = !bus.Stall && !bus.Ret && bus.JBP_enable && bus.Call;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel = SEL_INC;
    if (bus.Stall) begin
      sel = SEL_HOLD;
    end else if (bus.Ret) begin
      // Underflow falls through to the sequential increment.
      sel = ras_empty ? SEL_INC : SEL_RET;
    end else if (bus.JBP_enable) begin
      sel = SEL_JB;
    end
  end

  always_comb begin
    pc_d = pc_inc;
    unique case (sel)
      SEL_HOLD: pc_d = pc_q;
      SEL_RET:  pc_d = ras_top;
      SEL_JB:   pc_d = bus.JB_Target;
      SEL_INC:  pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_W;
    end else begin
      pc_q <= pc_d;
    end
  end

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_WIDTH  (PC_WIDTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_inc),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .full_o      (bus.RAS_Full),
    .err_o       (bus.RAS_Err)
  );

  assign bus.PC_Out    = pc_q;
  assign bus.PC_Next   = pc_d;
  assign bus.RAS_Empty = ras_empty;

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_d;

  // Only externally supplied addresses (target or popped return) are checked.
  assign misalign_d = ((sel == SEL_JB) || (sel == SEL_RET)) && ((pc_d % INC_W) != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (misalign_d) begin
      misalign_q <= 1'b1;
    end
  end

  assign Misalign = misalign_q;
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scoreboard bench for pc_seq_unit: the driver queues the expected post-edge
// state for each cycle, the monitor pops and compares on the falling edge.
module tb_pc_seq_unit;

  typedef struct {
    logic [15:0] pc;
    logic        empty;
    logic        full;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  pc_seq_unit_if #(.PC_WIDTH(16)) bus ();

  pc_seq_unit #(
    .PC_WIDTH  (16),
    .PC_INC    (2),
    .RESET_PC  (0),
    .RAS_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one expectation is pushed per rising edge and consumed here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("PC_Out",    32'(bus.PC_Out),    32'(e.pc));
        check("RAS_Empty", 32'(bus.RAS_Empty), 32'(e.empty));
        check("RAS_Full",  32'(bus.RAS_Full),  32'(e.full));
        check("RAS_Err",   32'(bus.RAS_Err),   32'(e.err));
      end
    end
  end

  task automatic step(input logic rst, input logic st, input logic jbp,
                      input logic [15:0] tgt, input logic call, input logic ret,
                      input logic [15:0] e_pc, input logic e_empty,
                      input logic e_full, input logic e_err);
    exp_t e;
    rst_n          = rst;
    bus.Stall      = st;
    bus.JBP_enable = jbp;
    bus.JB_Target  = tgt;
    bus.Call       = call;
    bus.Ret        = ret;
    @(posedge clk);
    e.pc = e_pc; e.empty = e_empty; e.full = e_full; e.err = e_err;
    sb_q.push_back(e);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //   rst st jbp tgt      call ret  pc       emp full err
    // Reset, then sequential increments.
    step(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
    step(1, 0, 0, 16'h0000, 0, 0, 16'h0002, 1, 0, 0);
    step(1, 0, 0, 16'h0000, 0, 0, 16'h0004, 1, 0, 0);
    step(1, 0, 0, 16'h0000, 0, 0, 16'h0006, 1, 0, 0);
    // Jump, then stall (second stall also asserts Call/Ret/JBP, all ignored).
    step(1, 0, 1, 16'h0010, 0, 0, 16'h0010, 1, 0, 0);
    step(1, 0, 1, 16'h1234, 0, 0, 16'h1234, 1, 0, 0);
    step(1, 1, 0, 16'h0000, 0, 0, 16'h1234, 1, 0, 0);
    step(1, 1, 1, 16'h9999, 1, 1, 16'h1234, 1, 0, 0);
    // Call and return.
    step(1, 0, 1, 16'h0020, 0, 0, 16'h0020, 1, 0, 0);
    step(1, 0, 1, 16'h0400, 1, 0, 16'h0400, 0, 0, 0);
    step(1, 0, 0, 16'h0000, 0, 1, 16'h0022, 1, 0, 0);
    // Call without JBP_enable is ignored.
    step(1, 0, 0, 16'h0700, 1, 0, 16'h0024, 1, 0, 0);
    // Five calls into a 4-deep stack: 0x12 is overwritten.
    step(1, 0, 1, 16'h0010, 0, 0, 16'h0010, 1, 0, 0);
    step(1, 0, 1, 16'h0020, 1, 0, 16'h0020, 0, 0, 0);
    step(1, 0, 1, 16'h0030, 1, 0, 16'h0030, 0, 0, 0);
    step(1, 0, 1, 16'h0040, 1, 0, 16'h0040, 0, 0, 0);
    step(1, 0, 1, 16'h0050, 1, 0, 16'h0050, 0, 1, 0);
    step(1, 0, 1, 16'h0060, 1, 0, 16'h0060, 0, 1, 1);
    step(1, 0, 0, 16'h0000, 0, 1, 16'h0052, 0, 0, 1);
    step(1, 0, 0, 16'h0000, 0, 1, 16'h0042, 0, 0, 1);
    step(1, 0, 0, 16'h0000, 0, 1, 16'h0032, 0, 0, 1);
    // Ret with Call+JBP: Ret wins, nothing pushed.
    step(1, 0, 1, 16'h0777, 1, 1, 16'h0022, 1, 0, 1);
    // Reset clears the sticky error; underflow at 0xFFFE wraps to 0.
    step(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
    step(1, 0, 1, 16'hFFFE, 0, 0, 16'hFFFE, 1, 0, 0);
    step(1, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 0, 1);
    // Ret beats JBP_enable.
    step(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
    step(1, 0, 1, 16'h00FE, 0, 0, 16'h00FE, 1, 0, 0);
    step(1, 0, 1, 16'h0300, 1, 0, 16'h0300, 0, 0, 0);
    step(1, 0, 1, 16'h0200, 0, 1, 16'h0100, 1, 0, 0);
    // Reset during a Call discards the push.
    step(1, 0, 1, 16'h0040, 0, 0, 16'h0040, 1, 0, 0);
    step(0, 0, 1, 16'h0500, 1, 0, 16'h0000, 1, 0, 0);
    step(1, 0, 0, 16'h0000, 0, 0, 16'h0002, 1, 0, 0);
    step(1, 0, 0, 16'h0000, 0, 1, 16'h0004, 1, 0, 1);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
Parametrised program-counter sequencer, successor to the two-way PC select.
- Holds the PC register and selects the next PC from four sources: increment, jump/branch target, return-address pop, and hold (stall).
- Contains a small return-address stack (RAS) for call/return.
- Sits between the fetch stage (instruction memory address) and the decode/branch logic of the single-cycle CPU.

Parameters:
- PC_WIDTH, 16, width of PC and all address ports.
- PC_INC, 2, byte increment per sequential instruction.
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- Stall  in  1  hold PC and RAS this cycle.
- JBP_enable  in  1  take jump/branch target.
- JB_Target  in  PC_WIDTH  jump/branch target address.
- Call  in  1  push PC+PC_INC onto RAS; valid only with JBP_enable.
- Ret  in  1  pop RAS top as next PC.
- PC_Out  out  PC_WIDTH  current PC (registered).
- PC_Next  out  PC_WIDTH  combinational next-PC value.
- RAS_Empty  out  1  RAS holds no entries.
- RAS_Full  out  1  RAS holds RAS_DEPTH entries.
- RAS_Err  out  1  sticky: overflow or underflow occurred.

Behaviour:
- Reset: when rst_n=0 at a rising edge, PC_Out=RESET_PC, RAS count=0, RAS_Empty=1, RAS_Full=0, RAS_Err=0. Stack contents are don't-care.
- Reset has priority over every other input. Asserting it mid-call/ret discards that operation.
- Next-PC priority: Stall > Ret > JBP_enable > increment.
  - Stall=1: PC_Next=PC_Out, no RAS change, Call/Ret ignored.
  - Ret=1: PC_Next=RAS top if RAS not empty.
  - Ret=1 with RAS empty (underflow): PC_Next=PC_Out+PC_INC and RAS_Err is set.
  - JBP_enable=1: PC_Next=JB_Target.
  - Otherwise: PC_Next=PC_Out+PC_INC.
- PC_Out updates to PC_Next on every rising edge when not in reset. Latency is one cycle from inputs to PC_Out.
- Arithmetic is modulo 2^PC_WIDTH; an increment from the maximum address wraps to 0.
- Call (requires JBP_enable=1, Stall=0, Ret=0): pushes PC_Out+PC_INC.
  - Call without JBP_enable is ignored.
  - Call and Ret together: Ret wins and Call is ignored.
- Overflow: a push while RAS_Full=1 overwrites the oldest entry (circular buffer). Count stays at RAS_DEPTH and RAS_Err is set.
- Pop decrements count; RAS top becomes the previous entry.
- RAS_Empty = (count==0); RAS_Full = (count==RAS_DEPTH). Both are registered-state derived.
- RAS_Err is sticky until reset.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined: adds output port Misalign (1 bit, registered, sticky until reset). It is set when a selected JB_Target or RAS pop value has low bits not a multiple of PC_INC. The PC still loads that value unmodified.
- When undefined: no Misalign port and no check logic.

Decomposition:
- Shared package pc_pkg holds:
  - the next-PC select encoding (SEL_HOLD, SEL_RET, SEL_JB, SEL_INC);
  - default constants PC_WIDTH_DEF, PC_INC_DEF, RESET_PC_DEF.
- One natural sub-module: pc_ras, the return-address stack. Parameters: RAS_DEPTH and PC_WIDTH. Ports: push, pop, push data, top, empty, full, err.
- The priority mux and PC register stay in pc_seq_unit.

Test Plan:
- Reset then 3 idle cycles → PC_Out 0x0000, 0x0002, 0x0004, 0x0006; RAS_Empty=1.
- PC_Out=0x0010 with JBP_enable=1, JB_Target=0x1234 → next PC_Out=0x1234. Then Stall=1 for 2 cycles → PC_Out stays 0x1234.
- PC_Out=0x0020 with Call+JBP_enable, JB_Target=0x0400 → PC_Out=0x0400. Then Ret=1 → PC_Out=0x0022, RAS_Empty=1, RAS_Err=0.
- 5 calls with RAS_DEPTH=4 from PCs 0x10, 0x20, 0x30, 0x40, 0x50 → RAS_Full=1, RAS_Err=1. Then 4 Rets yield 0x52, 0x42, 0x32, 0x22 (0x12 lost).
- Ret with RAS empty at PC_Out=0xFFFE → PC_Out=0x0000 (wrap), RAS_Err=1.
- Ret and JBP_enable together, RAS top=0x0100, JB_Target=0x0200 → PC_Out=0x0100.
- rst_n=0 during a Call cycle → PC_Out=RESET_PC, RAS_Empty=1.
